// File: rtl/uart_tx_sched_if.sv
// Signal bundle between uart_tx_sched, its byte requesters and the UART TX core.
// slave is the scheduler's view; master is the requester/core side.
interface uart_tx_sched_if #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
);
  logic [N_REQ-1:0]   req;
  logic [N_REQ*8-1:0] req_data;
  logic [N_REQ-1:0]   ack;
  logic [N_REQ-1:0]   done;
  logic               tx_start;
  logic [7:0]         tx_data;
  logic               tx_busy;
  logic               sched_busy;
  logic [ID_W-1:0]    grant_id;
  logic [15:0]        byte_cnt;
  logic               timeout_err;

  modport slave (
    input  req, req_data, tx_busy,
    output ack, done, tx_start, tx_data, sched_busy, grant_id, byte_cnt, timeout_err
  );

  modport master (
    output req, req_data, tx_busy,
    input  ack, done, tx_start, tx_data, sched_busy, grant_id, byte_cnt, timeout_err
  );
endinterface

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART TX core; req->tx_start 1 cycle, holds tx_start until tx_busy.
// Optional watchdog abort enabled by UART_SCHED_TIMEOUT_EN (otherwise waits on the core indefinitely).
module uart_tx_sched #(
  parameter int N_REQ       = 4,
  parameter int ID_W        = 2,
  parameter int TIMEOUT_CYC = 65535
) (
  input logic            clk,
  input logic            rst_n,
  uart_tx_sched_if.slave bus
);
  typedef enum logic [1:0] {IDLE, START, WAIT_BUSY_LOW} state_t;

  state_t           state, state_nxt;
  logic [N_REQ-1:0] ack_q, ack_nxt, done_q, done_nxt;
  logic             tx_start_q, tx_start_nxt;
  logic [7:0]       tx_data_q, tx_data_nxt;
  logic [ID_W-1:0]  grant_q, grant_nxt, rr_ptr, rr_nxt;
  logic [15:0]      cnt_q, cnt_nxt;
  logic [N_REQ-1:0] rot;
  logic             any_req;
  logic [ID_W-1:0]  winner;
  logic [ID_W:0]    sum;
  logic [7:0]       win_data;
  logic [ID_W-1:0]  grant_inc;
  logic             wd_hit;
  logic             abort;

  // Rotate requests so bit 0 is the rr pointer; the lowest set bit wins.
  assign rot = N_REQ'({bus.req, bus.req} >> rr_ptr);

  always_comb begin
    any_req = 1'b0;
    winner  = '0;
    sum     = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        any_req = 1'b1;
        sum     = {1'b0, rr_ptr} + (ID_W + 1)'(k);
        winner  = (sum >= (ID_W + 1)'(N_REQ)) ? ID_W'(sum - (ID_W + 1)'(N_REQ)) : ID_W'(sum);
      end
    end
  end

  always_comb begin
    win_data = 8'h00;
    for (int i = 0; i < N_REQ; i++) begin
      if (winner == ID_W'(i)) win_data = bus.req_data[8*i +: 8];
    end
  end

  assign grant_inc = (grant_q == ID_W'(N_REQ - 1)) ? '0 : grant_q + 1'b1;

  always_comb begin
    state_nxt    = state;
    ack_nxt      = '0;
    done_nxt     = '0;
    tx_start_nxt = tx_start_q;
    tx_data_nxt  = tx_data_q;
    grant_nxt    = grant_q;
    rr_nxt       = rr_ptr;
    cnt_nxt      = cnt_q;
    abort        = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) begin
          state_nxt    = START;
          tx_data_nxt  = win_data;
          grant_nxt    = winner;
          ack_nxt      = N_REQ'(1) << winner;
          tx_start_nxt = 1'b1;
        end
      end
      START: begin
        if (bus.tx_busy) begin
          tx_start_nxt = 1'b0;
          state_nxt    = WAIT_BUSY_LOW;
        end
      end
      WAIT_BUSY_LOW: begin
        if (!bus.tx_busy) begin
          done_nxt  = N_REQ'(1) << grant_q;
          cnt_nxt   = cnt_q + 16'd1;
          rr_nxt    = grant_inc;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // A normal handshake step on the same edge wins over the watchdog.
    if (wd_hit && (state_nxt == state)) begin
      abort        = 1'b1;
      state_nxt    = IDLE;
      tx_start_nxt = 1'b0;
      rr_nxt       = grant_inc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ack_q      <= '0;
      done_q     <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
      grant_q    <= '0;
      rr_ptr     <= '0;
      cnt_q      <= '0;
    end else begin
      state      <= state_nxt;
      ack_q      <= ack_nxt;
      done_q     <= done_nxt;
      tx_start_q <= tx_start_nxt;
      tx_data_q  <= tx_data_nxt;
      grant_q    <= grant_nxt;
      rr_ptr     <= rr_nxt;
      cnt_q      <= cnt_nxt;
    end
  end

`ifdef UART_SCHED_TIMEOUT_EN
  localparam logic [15:0] WD_LIM = 16'(TIMEOUT_CYC - 1);

  logic [15:0] wd_q;
  logic        to_err_q;

  assign wd_hit = (state != IDLE) && (wd_q == WD_LIM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_q     <= '0;
      to_err_q <= 1'b0;
    end else begin
      if (state_nxt != state) wd_q <= '0;
      else if (state != IDLE) wd_q <= wd_q + 16'd1;
      if (abort) to_err_q <= 1'b1;
    end
  end

  assign bus.timeout_err = to_err_q;
`else
  logic unused_timeout;

  assign wd_hit          = 1'b0;
  assign bus.timeout_err = 1'b0;
  assign unused_timeout  = ^{abort, 16'(TIMEOUT_CYC)};
`endif

  assign bus.ack        = ack_q;
  assign bus.done       = done_q;
  assign bus.tx_start   = tx_start_q;
  assign bus.tx_data    = tx_data_q;
  assign bus.sched_busy = (state != IDLE);
  assign bus.grant_id   = grant_q;
  assign bus.byte_cnt   = cnt_q;
endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
Round-robin scheduler that shares one UART transmitter core among N_REQ byte requesters, such as firmware mailbox, LA bridge and debug streamer.
- Arbitrates pending requests and latches the winning byte.
- Sequences the core's start/busy handshake and returns per-requester accept/done pulses.
- Sits in the user project between requester logic and the uart TX core driving mprj_io[6].

Parameters:
N_REQ, 4, number of requesters (2..8)
ID_W, 2, width of grant_id; must equal clog2(N_REQ)
TIMEOUT_CYC, 65535, watchdog limit in clk cycles (used only with UART_SCHED_TIMEOUT_EN)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
req  in  N_REQ  level request per requester; hold high until ack
req_data  in  N_REQ*8  byte per requester; slice i = req_data[8*i+7:8*i]
ack  out  N_REQ  1-cycle pulse: byte of requester i latched
done  out  N_REQ  1-cycle pulse: byte of requester i fully transmitted
tx_start  out  1  start strobe to UART core
tx_data  out  8  byte to UART core, stable while tx_start or tx_busy high
tx_busy  in  1  UART core busy (high from accept until stop bit sent)
sched_busy  out  1  high in any state other than IDLE
grant_id  out  ID_W  index of current or last granted requester
byte_cnt  out  16  count of completed bytes, wraps FFFF->0000
timeout_err  out  1  sticky watchdog flag (0 when feature compiled out)

Behaviour:
- Reset values: ack=0, done=0, tx_start=0, tx_data=8'h00, sched_busy=0, grant_id=0, byte_cnt=0, timeout_err=0, rr pointer=0, state=IDLE. Reset is asynchronous and may assert in any state; tx_start drops to 0 without waiting for a clock edge.
- FSM states: IDLE, START, WAIT_BUSY_LOW.
- IDLE, when any req bit is high:
  - Winner is the first requester with req high, searching from rr pointer upward modulo N_REQ.
  - Same edge: tx_data <= slice of winner, grant_id <= winner, ack[winner] pulses for 1 cycle, tx_start <= 1, state -> START.
  - Latency from req high (in IDLE) to tx_start high is 1 cycle.
- START: tx_start held at 1 until tx_busy is sampled high. On that edge: tx_start <= 0, state -> WAIT_BUSY_LOW.
- WAIT_BUSY_LOW: when tx_busy is sampled low, on the same edge:
  - done[grant_id] pulses for 1 cycle.
  - byte_cnt increments.
  - rr pointer <= grant_id+1 (mod N_REQ).
  - state -> IDLE.
- Minimum gap: one IDLE cycle between consecutive tx_start assertions.
- Fairness: a requester re-asserting req immediately after its done is served only after all other pending requesters in rr order.
- After ack, a requester may change req_data or drop req freely; the latched byte is unaffected.
- A req dropped before ack is simply not granted. No partial grant.
- tx_busy already high on entry to START: accept on the next edge (no deadlock).
- N_REQ=1: degenerates to a pass-through sequencer.
- byte_cnt wraps silently.

Optional Feature:
Macro UART_SCHED_TIMEOUT_EN.
- Defined:
  - A 16-bit watchdog clears on every state change and counts each cycle in START or WAIT_BUSY_LOW.
  - Reaching TIMEOUT_CYC: tx_start <= 0, state -> IDLE, timeout_err <= 1 (sticky until reset), rr pointer advances past grant_id.
  - No done pulse and no byte_cnt increment for the aborted byte.
- Undefined: no counter logic is present, timeout_err is tied to 0, and the FSM may wait indefinitely.

Test Plan:
- Single requester: req[2]=1, data 8'h0F, core asserts busy 2 cycles after start and holds 200 cycles -> ack[2] 1 cycle after req; tx_data=0F; tx_start high until busy; done[2] after busy falls; byte_cnt=1.
- All four request simultaneously after reset with data 0F,3D,10,33 -> grant order 0,1,2,3; tx_data sequence 0F,3D,10,33; four done pulses; byte_cnt=4.
- Requester 1 re-requests right after its done while 3 is pending -> 3 granted before 1.
- Requester changes req_data to 8'hFF the cycle after ack -> tx_data stays at the latched value through the whole busy window.
- rst_n asserted mid-WAIT_BUSY_LOW -> all outputs return to reset values asynchronously; after release, a new req is served starting from requester 0.
- With UART_SCHED_TIMEOUT_EN and TIMEOUT_CYC=100, tx_busy never rises -> tx_start drops after 100 cycles, timeout_err=1, no done pulse, next requester is granted. Without the macro: timeout_err stays 0 and tx_start stays high.
